// File: rtl/data_mem_responder.sv
// Byte-addressed, big-endian word memory with a strobe-driven request/ready
// handshake, programmable wait states and error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        nRD,
    input  logic        nWR,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        Busy,
    output logic        Err
);

    localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic            rd_q;
    logic            wr_q;
    logic            ill_q;
    logic [7:0]      mem [DEPTH_BYTES];

    logic [31:0]     cur_addr;
    logic            cur_rd;
    logic            cur_ill;
    logic            cur_bad;
    logic [AW-1:0]   idx;
    logic [31:0]     cur_word;

    // In IDLE the access resolves from live inputs (zero-wait path); later from the latched copy.
    always_comb begin
        cur_addr = addr_q;
        cur_rd   = rd_q;
        cur_ill  = ill_q;
        if (state == IDLE) begin
            cur_addr = Addr;
            cur_rd   = !nRD && nWR;
            cur_ill  = !nRD && !nWR;
        end
        cur_bad  = cur_ill || (cur_addr[1:0] != 2'b00) ||
                   ({1'b0, cur_addr} + 33'd3 >= 33'(DEPTH_BYTES));
        idx      = cur_addr[AW-1:0];
        cur_word = {mem[idx], mem[idx + AW'(1)], mem[idx + AW'(2)], mem[idx + AW'(3)]};
    end

    // Control FSM; Ready/Err/DataOut are loaded on entry to DONE.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= IDLE;
            count   <= '0;
            Ready   <= 1'b0;
            Err     <= 1'b0;
            Busy    <= 1'b0;
            DataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!nRD || !nWR) begin
                        addr_q <= Addr;
                        data_q <= DataIn;
                        rd_q   <= !nRD && nWR;
                        wr_q   <= nRD && !nWR;
                        ill_q  <= !nRD && !nWR;
                        Busy   <= 1'b1;
                        if (cur_ill || WAIT_CYCLES == 0) begin
                            state <= DONE;
                            Ready <= 1'b1;
                            Err   <= cur_bad;
                            if (cur_bad)     DataOut <= '0;
                            else if (cur_rd) DataOut <= cur_word;
                        end else begin
                            state <= WAIT;
                            count <= CW'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (count == CW'(1)) begin
                        state <= DONE;
                        count <= '0;
                        Ready <= 1'b1;
                        Err   <= cur_bad;
                        if (cur_bad)     DataOut <= '0;
                        else if (cur_rd) DataOut <= cur_word;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    state <= HOLD;
                    Ready <= 1'b0;
                    Err   <= 1'b0;
                end
                HOLD: begin
                    if (nRD && nWR) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a write commits on the DONE-exit edge unless reset intervenes.
    always_ff @(posedge CLK) begin
        if (Reset && state == DONE && wr_q && !Err) begin
            mem[addr_q[AW-1:0]]           <= data_q[31:24];
            mem[addr_q[AW-1:0] + AW'(1)]  <= data_q[23:16];
            mem[addr_q[AW-1:0] + AW'(2)]  <= data_q[15:8];
            mem[addr_q[AW-1:0] + AW'(3)]  <= data_q[7:0];
        end
    end

endmodule
